// File: rtl/io_mem_burst_access_if.sv
// ============================================================================
// Module   : io_mem_burst_access_if
// Brief    : Host request/response channel plus global/local/stream target buses
// Revision : 1.0
// ============================================================================
`default_nettype none

interface io_mem_burst_access_if #(
   parameter int DATA_L = 32,
   parameter int ADDR_L = 32,
   parameter int LEN_L  = 4,
   parameter int N_PE   = 8
);
   logic                         req_vld;
   logic                         req_rdy;
   logic                         req_wr;
   logic [ADDR_L-1:0]            req_addr;
   logic [DATA_L-1:0]            req_data;
   logic [LEN_L-1:0]             req_len;

   logic [ADDR_L-1:0]            glb_addr;
   logic                         glb_vld;
   logic                         glb_wr_en;
   logic [DATA_L-1:0]            glb_wr_data;
   logic [DATA_L-1:0]            glb_rd_data;
   logic                         glb_rd_data_vld;

   logic [ADDR_L-1:0]            loc_addr;
   logic [N_PE-1:0]              loc_vld;
   logic [N_PE-1:0]              loc_wr_en;
   logic [DATA_L-1:0]            loc_wr_data;
   logic [N_PE-1:0][DATA_L-1:0]  loc_rd_data;
   logic [N_PE-1:0]              loc_rd_data_vld;

   logic [ADDR_L-1:0]            str_addr;
   logic                         str_wr_vld;
   logic                         str_rd_vld;
   logic [DATA_L-1:0]            str_wr_data;
   logic [DATA_L-1:0]            str_rd_data;
   logic                         str_rd_data_vld;

   logic                         rsp_vld;
   logic                         rsp_rdy;
   logic [DATA_L-1:0]            rsp_data;
   logic                         rsp_err;
   logic                         busy;
   logic                         err_timeout;

   modport master (
      output req_vld, req_wr, req_addr, req_data, req_len,
      output glb_rd_data, glb_rd_data_vld, loc_rd_data, loc_rd_data_vld,
      output str_rd_data, str_rd_data_vld, rsp_rdy,
      input  req_rdy, glb_addr, glb_vld, glb_wr_en, glb_wr_data,
      input  loc_addr, loc_vld, loc_wr_en, loc_wr_data,
      input  str_addr, str_wr_vld, str_rd_vld, str_wr_data,
      input  rsp_vld, rsp_data, rsp_err, busy, err_timeout
   );

   modport slave (
      input  req_vld, req_wr, req_addr, req_data, req_len,
      input  glb_rd_data, glb_rd_data_vld, loc_rd_data, loc_rd_data_vld,
      input  str_rd_data, str_rd_data_vld, rsp_rdy,
      output req_rdy, glb_addr, glb_vld, glb_wr_en, glb_wr_data,
      output loc_addr, loc_vld, loc_wr_en, loc_wr_data,
      output str_addr, str_wr_vld, str_rd_vld, str_wr_data,
      output rsp_vld, rsp_data, rsp_err, busy, err_timeout
   );
endinterface

`default_nettype wire

// File: rtl/io_mem_burst_access.sv
// ============================================================================
// Module   : io_mem_burst_access
// Brief    : Burst-capable host access engine for global/local/stream memories
// Revision : 1.0
// ============================================================================
`default_nettype none

module io_mem_burst_access #(
   parameter int DATA_L           = 32,
   parameter int ADDR_L           = 32,
   parameter int ADDR_TYPE_L      = 2,
   parameter int TYPE_GLOBAL      = 0,
   parameter int TYPE_LOCAL       = 1,
   parameter int TYPE_STREAM      = 2,
   parameter int N_PE             = 8,
   parameter int LOCAL_MEM_ADDR_L = 10,
   parameter int LEN_L            = 4,
   parameter int FIFO_DEPTH       = 8,
   parameter int TIMEOUT_CYC      = 64
) (
   input wire logic             clk,
   input wire logic             rst,
   io_mem_burst_access_if.slave bus
);
   localparam int BANK_L = $clog2(N_PE);
   localparam int PTR_L  = $clog2(FIFO_DEPTH);
   localparam int CNT_L  = PTR_L + 1;
   localparam int TMO_L  = $clog2(TIMEOUT_CYC + 1);
   localparam int OFS_L  = ADDR_L - ADDR_TYPE_L;

   typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD, ST_DRAIN} state_t;
   state_t r_state, w_state_nxt;

   logic [ADDR_TYPE_L-1:0] r_type;
   logic [ADDR_L-1:0]      r_addr;
   logic [LEN_L-1:0]       r_left;
   logic [CNT_L-1:0]       r_outst, r_fcnt;
   logic [TMO_L-1:0]       r_tmo;
   logic [PTR_L-1:0]       r_wptr, r_rptr;
   logic [DATA_L-1:0]      r_fdata [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0]  r_ferr;
   logic                   r_err_timeout;

   logic                   w_accept, w_req_legal, w_cur_legal, w_credit, w_issue, w_inc;
   logic                   w_tgt_vld, w_rsp_push, w_err_push, w_push, w_pop, w_tmo_hit;
   logic [DATA_L-1:0]      w_tgt_data;
   logic [ADDR_TYPE_L-1:0] w_req_type;
   logic [ADDR_L-1:0]      w_addr_nxt;

   function automatic logic type_legal(input logic [ADDR_TYPE_L-1:0] t);
      return (t == ADDR_TYPE_L'(TYPE_GLOBAL)) || (t == ADDR_TYPE_L'(TYPE_LOCAL)) ||
             (t == ADDR_TYPE_L'(TYPE_STREAM));
   endfunction

   function automatic logic [N_PE-1:0] bank_oh(input logic [ADDR_L-1:0] a);
      return N_PE'(1) << a[LOCAL_MEM_ADDR_L +: BANK_L];
   endfunction

   assign w_req_type  = bus.req_addr[ADDR_L-1 -: ADDR_TYPE_L];
   assign w_req_legal = type_legal(w_req_type);
   assign w_cur_legal = type_legal(r_type);
   assign w_accept    = bus.req_vld && (r_state == ST_IDLE);
   // Type field is held; only the offset part wraps, carrying across local banks.
   assign w_addr_nxt  = {r_addr[ADDR_L-1 -: ADDR_TYPE_L], r_addr[OFS_L-1:0] + OFS_L'(1)};
   assign w_credit    = ({1'b0, r_outst} + {1'b0, r_fcnt}) < (CNT_L+1)'(FIFO_DEPTH);
   assign w_tmo_hit   = (r_outst != '0) && !w_tgt_vld && (r_tmo == TMO_L'(TIMEOUT_CYC - 1));
   assign w_issue     = (r_state == ST_RD) && w_credit && !w_tmo_hit;
   assign w_inc       = w_issue && w_cur_legal;
   assign w_rsp_push  = w_tgt_vld && (r_outst != '0);
   assign w_err_push  = w_issue && !w_cur_legal;
   assign w_push      = w_rsp_push || w_err_push;
   assign w_pop       = bus.rsp_vld && bus.rsp_rdy;

   assign bus.req_rdy     = (r_state == ST_IDLE);
   assign bus.busy        = (r_state != ST_IDLE);
   assign bus.rsp_vld     = (r_fcnt != '0);
   assign bus.rsp_data    = bus.rsp_vld ? r_fdata[r_rptr] : '0;
   assign bus.rsp_err     = bus.rsp_vld && r_ferr[r_rptr];
   assign bus.err_timeout = r_err_timeout;

   always_comb begin
      w_tgt_vld  = 1'b0;
      w_tgt_data = '0;
      if (r_type == ADDR_TYPE_L'(TYPE_GLOBAL)) begin
         w_tgt_vld  = bus.glb_rd_data_vld;
         w_tgt_data = bus.glb_rd_data;
      end else if (r_type == ADDR_TYPE_L'(TYPE_LOCAL)) begin
         for (int i = 0; i < N_PE; i++) begin
            if (bus.loc_rd_data_vld[i]) begin
               w_tgt_vld  = 1'b1;
               w_tgt_data = bus.loc_rd_data[i];
            end
         end
      end else if (r_type == ADDR_TYPE_L'(TYPE_STREAM)) begin
         w_tgt_vld  = bus.str_rd_data_vld;
         w_tgt_data = bus.str_rd_data;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_accept) w_state_nxt = !bus.req_wr ? ST_RD : (w_req_legal ? ST_WR : ST_IDLE);
         ST_WR:    w_state_nxt = ST_IDLE;
         ST_RD:    if (w_tmo_hit) w_state_nxt = ST_IDLE;
                   else if (w_issue && (r_left == '0)) w_state_nxt = ST_DRAIN;
         ST_DRAIN: if (w_tmo_hit || (r_outst == '0)) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= ST_IDLE;
         r_type        <= '0;
         r_addr        <= '0;
         r_left        <= '0;
         r_outst       <= '0;
         r_fcnt        <= '0;
         r_tmo         <= '0;
         r_wptr        <= '0;
         r_rptr        <= '0;
         r_ferr        <= '0;
         r_err_timeout <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_type <= w_req_type;
            r_addr <= bus.req_addr;
            r_left <= bus.req_len;
         end else if (w_issue) begin
            r_addr <= w_addr_nxt;
            if (r_left != '0) r_left <= r_left - LEN_L'(1);
         end
         if (w_tmo_hit)                  r_outst <= '0;
         else if (w_inc && !w_rsp_push)  r_outst <= r_outst + CNT_L'(1);
         else if (!w_inc && w_rsp_push)  r_outst <= r_outst - CNT_L'(1);
         if ((r_outst == '0) || w_rsp_push || w_tmo_hit) r_tmo <= '0;
         else                                            r_tmo <= r_tmo + TMO_L'(1);
         if (w_accept)       r_err_timeout <= 1'b0;
         else if (w_tmo_hit) r_err_timeout <= 1'b1;
         if (w_push) begin
            r_ferr[r_wptr] <= w_err_push;
            r_wptr         <= r_wptr + PTR_L'(1);
         end
         if (w_pop) r_rptr <= r_rptr + PTR_L'(1);
         if (w_push && !w_pop)      r_fcnt <= r_fcnt + CNT_L'(1);
         else if (!w_push && w_pop) r_fcnt <= r_fcnt - CNT_L'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_fdata[r_wptr] <= w_err_push ? '0 : w_tgt_data;
   end

   // Target strobes are single-cycle registered pulses; addresses/data hold between strobes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.glb_addr    <= '0;
         bus.glb_vld     <= 1'b0;
         bus.glb_wr_en   <= 1'b0;
         bus.glb_wr_data <= '0;
         bus.loc_addr    <= '0;
         bus.loc_vld     <= '0;
         bus.loc_wr_en   <= '0;
         bus.loc_wr_data <= '0;
         bus.str_addr    <= '0;
         bus.str_wr_vld  <= 1'b0;
         bus.str_rd_vld  <= 1'b0;
         bus.str_wr_data <= '0;
      end else begin
         bus.glb_vld    <= 1'b0;
         bus.glb_wr_en  <= 1'b0;
         bus.loc_vld    <= '0;
         bus.loc_wr_en  <= '0;
         bus.str_wr_vld <= 1'b0;
         bus.str_rd_vld <= 1'b0;
         if (w_accept && bus.req_wr && w_req_legal) begin
            if (w_req_type == ADDR_TYPE_L'(TYPE_GLOBAL)) begin
               bus.glb_vld     <= 1'b1;
               bus.glb_wr_en   <= 1'b1;
               bus.glb_addr    <= bus.req_addr;
               bus.glb_wr_data <= bus.req_data;
            end else if (w_req_type == ADDR_TYPE_L'(TYPE_LOCAL)) begin
               bus.loc_vld     <= bank_oh(bus.req_addr);
               bus.loc_wr_en   <= bank_oh(bus.req_addr);
               bus.loc_addr    <= bus.req_addr;
               bus.loc_wr_data <= bus.req_data;
            end else begin
               bus.str_wr_vld  <= 1'b1;
               bus.str_addr    <= bus.req_addr;
               bus.str_wr_data <= bus.req_data;
            end
         end else if (w_inc) begin
            if (r_type == ADDR_TYPE_L'(TYPE_GLOBAL)) begin
               bus.glb_vld  <= 1'b1;
               bus.glb_addr <= r_addr;
            end else if (r_type == ADDR_TYPE_L'(TYPE_LOCAL)) begin
               bus.loc_vld  <= bank_oh(r_addr);
               bus.loc_addr <= r_addr;
            end else begin
               bus.str_rd_vld <= 1'b1;
               bus.str_addr   <= r_addr;
            end
         end
      end
   end
endmodule

`default_nettype wire

// File: doc/io_mem_burst_access.md
Name: io_mem_burst_access

Overview:
- Host-side initialisation and debug access engine for the global memory, the per-PE local memory banks and the instruction stream.
- Accepts single-beat writes and multi-beat auto-incrementing read bursts over a valid/ready request channel.
- Decodes the address type field, registers all target strobes, and buffers read data in a response FIFO under a credit scheme.
- Flags decode errors and read timeouts. It is the sequential, burst-capable successor of the combinational IO access path.

Parameters:
- DATA_L, 32, data word width.
- ADDR_L, 32, request address width.
- ADDR_TYPE_L, 2, width of the type field in the address MSBs.
- TYPE_GLOBAL, 0, type code for global memory.
- TYPE_LOCAL, 1, type code for local memory.
- TYPE_STREAM, 2, type code for the instruction stream.
- N_PE, 8, number of local banks; must be a power of 2.
- LOCAL_MEM_ADDR_L, 10, word-address width within one local bank.
- LEN_L, 4, burst length field width; a burst has req_len+1 beats.
- FIFO_DEPTH, 8, response FIFO depth; power of 2, at least 2.
- TIMEOUT_CYC, 64, maximum wait for any single read response.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req_vld  in  1  request valid.
- req_rdy  out  1  request ready.
- req_wr  in  1  1 = write, 0 = read burst.
- req_addr  in  ADDR_L  start address.
- req_data  in  DATA_L  write data.
- req_len  in  LEN_L  read beats minus 1; ignored for writes.
- glb_addr  out  ADDR_L  global memory address.
- glb_vld  out  1  global access strobe.
- glb_wr_en  out  1  global write enable.
- glb_wr_data  out  DATA_L  global write data.
- glb_rd_data  in  DATA_L  global read data.
- glb_rd_data_vld  in  1  global read data valid.
- loc_addr  out  ADDR_L  local memory address.
- loc_vld  out  N_PE  one-hot local bank strobe.
- loc_wr_en  out  N_PE  one-hot local write enable.
- loc_wr_data  out  DATA_L  local write data.
- loc_rd_data  in  N_PE x DATA_L  local read data, per bank.
- loc_rd_data_vld  in  N_PE  local read data valid, per bank.
- str_addr  out  ADDR_L  stream address.
- str_wr_vld  out  1  stream write strobe.
- str_rd_vld  out  1  stream read strobe.
- str_wr_data  out  DATA_L  stream write data.
- str_rd_data  in  DATA_L  stream read data.
- str_rd_data_vld  in  1  stream read data valid.
- rsp_vld  out  1  response valid.
- rsp_rdy  in  1  response ready.
- rsp_data  out  DATA_L  response data.
- rsp_err  out  1  response carries a decode error.
- busy  out  1  engine not IDLE.
- err_timeout  out  1  sticky read-timeout flag.

Behaviour:
Reset:
- All outputs are 0 at reset, except req_rdy, which is 1.
- FIFO empty, outstanding count 0, FSM in IDLE.

Acceptance and decode:
- A request is accepted on req_vld & req_rdy.
- req_rdy = 1 only in IDLE.
- Type = req_addr[ADDR_L-1 -: ADDR_TYPE_L].
- Local bank = addr[LOCAL_MEM_ADDR_L +: log2(N_PE)].

FSM states:
- IDLE, on accept:
  - write with legal type -> WR;
  - write with illegal type -> IDLE; request dropped, no response, no strobe;
  - read -> RD.
- WR: target strobes are asserted for exactly 1 cycle, the cycle after accept (registered outputs). Next state is IDLE.
- RD: issues one beat per cycle while credit is available.
  - Credit = outstanding + fifo_count < FIFO_DEPTH.
  - A beat with no credit stalls, strobes low.
  - Address increments by 1 per beat, modulo 2^(ADDR_L-ADDR_TYPE_L); the type field is held.
  - A local burst crossing a bank boundary moves to the next bank; from the last bank it wraps to bank 0.
  - Illegal-type read beats issue no strobe. They push DATA = 0 with rsp_err = 1 directly into the FIFO (credit checked).
  - After the last beat is issued -> DRAIN.
- DRAIN: waits until outstanding == 0 -> IDLE.
- busy = (state != IDLE).

Responses:
- A target rd_data_vld while outstanding > 0 pushes data into the FIFO with rsp_err = 0 and decrements outstanding.
- rsp_vld rises the cycle after the push.
- The FIFO pops on rsp_vld & rsp_rdy. Push and pop in the same cycle are both performed.
- Any rd_data_vld while outstanding == 0 is discarded.
- Targets respond in order. Only the target type of the current burst is sampled.

Timeout:
- A counter resets on each response, or whenever outstanding == 0.
- When it reaches TIMEOUT_CYC, err_timeout is set, outstanding is cleared and the FSM goes to IDLE. Missing beats are never returned.
- err_timeout clears on the next accepted request.

Asynchronous reset mid-burst:
- Aborts immediately.
- Returns to the reset state; FIFO contents are lost.

Test Plan:
- Write 0xA5A5_0001 to addr type LOCAL, bank 3, offset 0x10 -> exactly one cycle with loc_vld = 8'b0000_1000, loc_wr_en = 8'b0000_1000, loc_addr offset 0x10, loc_wr_data = 0xA5A5_0001; req_rdy low that cycle.
- Global read, req_len = 3, addr 0x100, memory returning addr+0x1000 with 2-cycle latency, rsp_rdy = 1 -> 4 responses: 0x1100, 0x1101, 0x1102, 0x1103; busy falls after the last response.
- Global read, req_len = 15, FIFO_DEPTH = 8, rsp_rdy = 0 -> exactly 8 strobes issued, then stall. Raising rsp_rdy resumes issue; all 16 beats are returned in order with no loss.
- Local read starting at bank 0, offset 1023, req_len = 1 -> strobes loc_vld = 0x01 at offset 1023, then loc_vld = 0x02 at offset 0.
- Stream read, target never answers -> err_timeout = 1 exactly TIMEOUT_CYC cycles after the strobe; state IDLE, no rsp_vld. A late str_rd_data_vld is ignored. The next accepted request clears err_timeout.
- Read with type 3, req_len = 1 -> no strobes; 2 responses with data 0 and rsp_err = 1. Write with type 3 -> no strobe, no response.
- Assert rst low mid-burst -> all outputs 0 except req_rdy = 1, FIFO empty.
